// File: rtl/seven_seg_scan_controller_pkg.sv
// Shared types and constants for the seven-segment scan controller slice.
package seven_seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] BCD_BLANK = 4'hF;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        COMMIT  = 2'd2
    } scan_state_t;

    // BCD pattern with every digit set to 9, used as the saturated display value
    function automatic logic [4*16-1:0] all_nines();
        logic [4*16-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            r[i*4 +: 4] = 4'd9;
        end
        return r;
    endfunction

endpackage

// File: rtl/seven_seg_scan_controller_if.sv
// Value handshake between game logic (master) and the scan controller (slave).
interface seven_seg_scan_controller_if #(
    parameter int VALUE_W = 14
) ();

    logic               value_valid;
    logic [VALUE_W-1:0] value;
    logic               value_ready;

    modport master (output value_valid, output value, input value_ready);
    modport slave  (input value_valid, input value, output value_ready);

endinterface

// File: rtl/seven_seg_display_driver.sv
// Shared BCD-to-7-segment decoder, active-low {g,f,e,d,c,b,a}; non-decimal codes go dark.
module seven_seg_display_driver
    import seven_seg_pkg::*;
(
    input  bcd_t       digit,
    output logic [6:0] seg
);

    // Combinational digit pattern lookup
    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_controller.sv
// Binary-to-BCD (double-dabble, one bit per clock) plus time-multiplexed
// common-anode 7-segment scanning through one shared decoder.
module seven_seg_scan_controller
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int VALUE_W     = 14,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_LZ    = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    seven_seg_scan_controller_if.slave val_if,
    input  logic                    enable,
    output logic                    overflow,
    output logic [6:0]              segments,
    output logic [NUM_DIGITS-1:0]   anodes
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(VALUE_W + 1);
    localparam int REF_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [63:0] MAX_VAL = 64'(10 ** NUM_DIGITS - 1);
    localparam logic [4*16-1:0] NINES_ALL = all_nines();
    localparam logic [BCD_W-1:0] NINES = NINES_ALL[BCD_W-1:0];

    scan_state_t            state_q, state_d;
    logic [VALUE_W-1:0]     shreg_q, shreg_d;
    logic [BCD_W-1:0]       bcd_q, bcd_d;
    logic                   ovf_pend_q, ovf_pend_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [BCD_W-1:0]       disp_q, disp_d;
    logic                   overflow_q, overflow_d;
    logic [REF_W-1:0]       ref_cnt_q, ref_cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [6:0]             seg_q, seg_d;
    logic [NUM_DIGITS-1:0]  an_q, an_d;

    logic [BCD_W-1:0]       adj;
    logic [NUM_DIGITS-1:0]  lz;
    logic                   zero_above;
    bcd_t                   cur_nib;
    logic [6:0]             dec_seg;

    assign val_if.value_ready = (state_q == IDLE);
    assign overflow = overflow_q;
    assign segments = seg_q;
    assign anodes   = an_q;

    // Conversion FSM: capture, VALUE_W add-3/shift steps, then commit to display
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bcd_d      = bcd_q;
        ovf_pend_d = ovf_pend_q;
        bit_cnt_d  = bit_cnt_q;
        disp_d     = disp_q;
        overflow_d = overflow_q;
        adj        = bcd_q;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
        case (state_q)
            IDLE: begin
                if (val_if.value_valid) begin
                    shreg_d    = val_if.value;
                    bcd_d      = '0;
                    ovf_pend_d = (64'(val_if.value) > MAX_VAL);
                    bit_cnt_d  = '0;
                    state_d    = CONVERT;
                end
            end
            CONVERT: begin
                bcd_d     = {adj[BCD_W-2:0], shreg_q[VALUE_W-1]};
                shreg_d   = shreg_q << 1;
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == CNT_W'(VALUE_W - 1)) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                disp_d     = ovf_pend_q ? NINES : bcd_q;
                overflow_d = ovf_pend_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Free-running refresh counter and digit index; leading-zero mask and digit mux
    always_comb begin
        ref_cnt_d = ref_cnt_q + 1'b1;
        idx_d     = idx_q;
        if (ref_cnt_q == REF_W'(REFRESH_DIV - 1)) begin
            ref_cnt_d = '0;
            idx_d     = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
        lz         = '0;
        zero_above = 1'b1;
        for (int unsigned i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above && (disp_q[i*4 +: 4] == 4'd0);
            lz[i]      = zero_above && (BLANK_LZ != 0);
        end
        cur_nib = BCD_BLANK;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (IDX_W'(i) == idx_q) begin
                cur_nib = lz[i] ? BCD_BLANK : disp_q[i*4 +: 4];
            end
        end
    end

    seven_seg_display_driver u_display_driver (
        .digit (cur_nib),
        .seg   (dec_seg)
    );

    // Registered pin drive: anode and segments for the current index change together
    always_comb begin
        seg_d = enable ? dec_seg : SEG_BLANK;
        an_d  = enable ? ~(NUM_DIGITS'(1) << idx_q) : '1;
    end

    // State registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bcd_q      <= '0;
            ovf_pend_q <= 1'b0;
            bit_cnt_q  <= '0;
            disp_q     <= '0;
            overflow_q <= 1'b0;
            ref_cnt_q  <= '0;
            idx_q      <= '0;
            seg_q      <= SEG_BLANK;
            an_q       <= '1;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bcd_q      <= bcd_d;
            ovf_pend_q <= ovf_pend_d;
            bit_cnt_q  <= bit_cnt_d;
            disp_q     <= disp_d;
            overflow_q <= overflow_d;
            ref_cnt_q  <= ref_cnt_d;
            idx_q      <= idx_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
        end
    end

endmodule
